// File: rtl/curve25519_pkg.sv
// rtl/curve25519_pkg.sv - shared width, state encoding and constants for the curve25519 arbiter
package curve25519_pkg;

  localparam int WIDTH = 255;

  // Standard curve25519 base point u-coordinate
  localparam logic [WIDTH-1:0] BASE_POINT = WIDTH'(9);

  typedef enum logic [2:0] {
    ST_QUIET,
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/curve25519_arbiter_if.sv
// rtl/curve25519_arbiter_if.sv - requester and core signal bundle for the curve25519 arbiter
interface curve25519_arbiter_if;
  import curve25519_pkg::*;

  logic             req0_valid;
  logic [WIDTH-1:0] req0_n;
  logic [WIDTH-1:0] req0_q;
  logic             req0_ack;
  logic             req0_done;
  logic [WIDTH-1:0] req0_out;
  logic             req0_err;

  logic             req1_valid;
  logic [WIDTH-1:0] req1_n;
  logic [WIDTH-1:0] req1_q;
  logic             req1_ack;
  logic             req1_done;
  logic [WIDTH-1:0] req1_out;
  logic             req1_err;

  logic             core_start;
  logic [WIDTH-1:0] core_n;
  logic [WIDTH-1:0] core_q;
  logic             core_done;
  logic [WIDTH-1:0] core_out;

  logic             busy;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_n, req0_q, req1_valid, req1_n, req1_q, core_done, core_out,
    output req0_ack, req0_done, req0_out, req0_err,
    output req1_ack, req1_done, req1_out, req1_err,
    output core_start, core_n, core_q, busy
  );

  // Requesters plus core side
  modport master (
    output req0_valid, req0_n, req0_q, req1_valid, req1_n, req1_q, core_done, core_out,
    input  req0_ack, req0_done, req0_out, req0_err,
    input  req1_ack, req1_done, req1_out, req1_err,
    input  core_start, core_n, core_q, busy
  );

endinterface

// File: rtl/curve25519_arbiter_rr_arbiter2.sv
// rtl/curve25519_arbiter_rr_arbiter2.sv - two-way round-robin grant with pointer update on accept
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic       grant,
  output logic       any
);

  // Pointer names the requester favoured when both are valid
  logic ptr;

  // A lone valid wins outright; a tie goes to the pointer
  always_comb begin
    any   = |valid;
    grant = (valid == 2'b11) ? ptr : valid[1];
  end

  // After an accepted grant the other requester becomes favoured
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (accept && any) begin
      ptr <= ~grant;
    end
  end

endmodule

// File: rtl/curve25519_arbiter.sv
// rtl/curve25519_arbiter.sv - shares one curve25519 core between two requesters; optional CURVE25519_TIMEOUT_EN
module curve25519_arbiter
  import curve25519_pkg::*;
#(
  parameter int RESET_QUIET    = 8
`ifdef CURVE25519_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  curve25519_arbiter_if.slave  bus
);

  localparam int QW = $clog2(RESET_QUIET + 1);

  state_t           state;
  state_t           next_state;
  logic [QW-1:0]    q_cnt;
  logic             owner;
  logic [WIDTH-1:0] n_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] out0_r;
  logic [WIDTH-1:0] out1_r;
  logic             grant;
  logic             any;
  logic             accept;
  logic             wait_expired;
  logic             timed_out;

  assign accept = (state == ST_IDLE);

  rr_arbiter2 u_rr (
    .clock  (clock),
    .reset  (reset),
    .valid  ({bus.req1_valid, bus.req0_valid}),
    .accept (accept),
    .grant  (grant),
    .any    (any)
  );

`ifdef CURVE25519_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] w_cnt;

  assign wait_expired = (w_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Count cycles spent in WAIT and remember whether the core was abandoned
  always_ff @(posedge clock) begin
    if (reset) begin
      w_cnt     <= '0;
      timed_out <= 1'b0;
    end else begin
      w_cnt <= (state == ST_WAIT) ? w_cnt + TW'(1) : '0;
      if (state == ST_ISSUE) begin
        timed_out <= 1'b0;
      end else if (state == ST_WAIT && !bus.core_done && wait_expired) begin
        timed_out <= 1'b1;
      end
    end
  end
`else
  assign wait_expired = 1'b0;
  assign timed_out    = 1'b0;
`endif

  // State, quiet counter, captured operands and per-requester results
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_QUIET;
      q_cnt  <= '0;
      owner  <= 1'b0;
      n_r    <= '0;
      q_r    <= '0;
      out0_r <= '0;
      out1_r <= '0;
    end else begin
      state <= next_state;
      q_cnt <= (state == ST_QUIET) ? q_cnt + QW'(1) : '0;
      if (accept && any) begin
        owner <= grant;
        n_r   <= grant ? bus.req1_n : bus.req0_n;
        q_r   <= grant ? bus.req1_q : bus.req0_q;
      end
      if (state == ST_WAIT) begin
        if (bus.core_done) begin
          if (owner) out1_r <= bus.core_out;
          else       out0_r <= bus.core_out;
        end else if (wait_expired) begin
          if (owner) out1_r <= '0;
          else       out0_r <= '0;
        end
      end
    end
  end

  // Next-state and one-cycle handshake pulses decoded from the current state
  always_comb begin
    next_state     = state;
    bus.req0_ack   = 1'b0;
    bus.req1_ack   = 1'b0;
    bus.req0_done  = 1'b0;
    bus.req1_done  = 1'b0;
    bus.req0_err   = 1'b0;
    bus.req1_err   = 1'b0;
    bus.core_start = 1'b0;
    bus.busy       = 1'b0;
    case (state)
      ST_QUIET: if (q_cnt == QW'(RESET_QUIET - 1)) next_state = ST_IDLE;
      ST_IDLE:  if (any) next_state = ST_ISSUE;
      ST_ISSUE: begin
        next_state     = ST_WAIT;
        bus.busy       = 1'b1;
        bus.core_start = 1'b1;
        bus.req0_ack   = !owner;
        bus.req1_ack   = owner;
      end
      ST_WAIT: begin
        bus.busy = 1'b1;
        if (bus.core_done || wait_expired) next_state = ST_RESP;
      end
      ST_RESP: begin
        bus.busy      = 1'b1;
        bus.req0_done = !owner;
        bus.req1_done = owner;
        bus.req0_err  = !owner && timed_out;
        bus.req1_err  = owner && timed_out;
        next_state    = timed_out ? ST_QUIET : ST_IDLE;
      end
      default: next_state = ST_QUIET;
    endcase
  end

  assign bus.core_n   = n_r;
  assign bus.core_q   = q_r;
  assign bus.req0_out = out0_r;
  assign bus.req1_out = out1_r;

endmodule

// File: tb/tb_curve25519_arbiter.sv
// tb/tb_curve25519_arbiter.sv - directed self-checking bench for curve25519_arbiter with a stub core
module tb_curve25519_arbiter;
  import curve25519_pkg::*;

  logic clock = 1'b0;
  logic reset;

  curve25519_arbiter_if bus ();

  curve25519_arbiter #(
    .RESET_QUIET(8)
`ifdef CURVE25519_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  logic [WIDTH-1:0] p33;
  logic [WIDTH-1:0] p22;
  initial begin
    p33 = WIDTH'({64{4'h3}});
    p22 = WIDTH'({64{4'h2}});
  end

  // Stub core: done four cycles after start; result depends on the point
  int   stub_cnt = 0;
  logic stub_dead = 1'b0;
  logic stub_pulse = 1'b0;
  always @(posedge clock) begin
    if (bus.core_start && !stub_dead) stub_cnt <= 4;
    else if (stub_cnt > 0)            stub_cnt <= stub_cnt - 1;
  end
  assign bus.core_done = (stub_cnt == 1) || stub_pulse;
  assign bus.core_out  = (bus.core_q == BASE_POINT) ? p33 : p22;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  int n_ack, n_done, n_err, outstanding, overlap;
  int ack_who[32], ack_cyc[32], done_who[32], done_cyc[32], err_cyc[32];
  logic drop0 = 1'b1, drop1 = 1'b1;

  task automatic clear_log();
    n_ack = 0; n_done = 0; n_err = 0; outstanding = 0; overlap = 0;
  endtask

  task automatic tick();
    @(negedge clock);
    cyc++;
    if (bus.req0_ack || bus.req1_ack) begin
      if (n_ack < 32) begin
        ack_who[n_ack] = bus.req1_ack ? 1 : 0;
        ack_cyc[n_ack] = cyc;
      end
      n_ack++;
      outstanding++;
      if (outstanding > 1) overlap++;
      if (bus.req0_ack && drop0) bus.req0_valid = 1'b0;
      if (bus.req1_ack && drop1) bus.req1_valid = 1'b0;
    end
    if (bus.req0_done || bus.req1_done) begin
      if (n_done < 32) begin
        done_who[n_done] = bus.req1_done ? 1 : 0;
        done_cyc[n_done] = cyc;
      end
      n_done++;
      outstanding--;
    end
    if (bus.req0_err || bus.req1_err) begin
      if (n_err < 32) err_cyc[n_err] = cyc;
      n_err++;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    repeat (10) tick();
    clear_log();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  int t0;
  int bad;

  initial begin
    reset = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_n = '0; bus.req0_q = '0;
    bus.req1_valid = 1'b0; bus.req1_n = '0; bus.req1_q = '0;
    clear_log();
    tick();
    tick();
    check("rst_ack0", bus.req0_ack, 0);
    check("rst_ack1", bus.req1_ack, 0);
    check("rst_done0", bus.req0_done, 0);
    check("rst_start", bus.core_start, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out0", bus.req0_out, 0);
    check("rst_core_n", bus.core_n, 0);
    check("rst_err1", bus.req1_err, 0);
    reset = 1'b0;
    repeat (10) tick();
    clear_log();

    // Single request on the base point
    t0 = cyc;
    bus.req0_n = WIDTH'(5); bus.req0_q = BASE_POINT; bus.req0_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 1) begin
        check("t1_ack0", bus.req0_ack, 1);
        check("t1_start", bus.core_start, 1);
        check("t1_core_n", bus.core_n, 5);
        check("t1_core_q", bus.core_q, 9);
      end
      check($sformatf("t1_busy_k%0d", k), bus.busy, (k <= 6));
      if (k == 6) begin
        check("t1_done0", bus.req0_done, 1);
        check("t1_out0", bus.req0_out, p33);
        check("t1_err0", bus.req0_err, 0);
      end
    end
    check("t1_n_done", n_done, 1);

    // Simultaneous requests after reset: req0 first, then req1
    do_reset();
    t0 = cyc;
    bus.req0_n = WIDTH'(5); bus.req0_q = BASE_POINT; bus.req0_valid = 1'b1;
    bus.req1_n = WIDTH'(3); bus.req1_q = WIDTH'(7);  bus.req1_valid = 1'b1;
    bad = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k >= 6 && bus.req0_out !== p33) bad++;
    end
    check("t2_n_ack", n_ack, 2);
    check("t2_first_who", ack_who[0], 0);
    check("t2_first_cyc", ack_cyc[0], t0 + 1);
    check("t2_second_who", ack_who[1], 1);
    check("t2_second_cyc", ack_cyc[1], t0 + 8);
    check("t2_done1_cyc", done_cyc[1], t0 + 13);
    check("t2_out1", bus.req1_out, p22);
    check("t2_out0_hold", bad, 0);
    check("t2_core_q", bus.core_q, 7);

    // Both held valid: grants alternate and never overlap
    do_reset();
    drop0 = 1'b0; drop1 = 1'b0;
    t0 = cyc;
    bus.req0_q = BASE_POINT; bus.req0_valid = 1'b1;
    bus.req1_q = WIDTH'(7);  bus.req1_valid = 1'b1;
    repeat (27) tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (3) tick();
    drop0 = 1'b1; drop1 = 1'b1;
    check("t3_n_ack", n_ack, 4);
    check("t3_who0", ack_who[0], 0);
    check("t3_who1", ack_who[1], 1);
    check("t3_who2", ack_who[2], 0);
    check("t3_who3", ack_who[3], 1);
    check("t3_cyc3", ack_cyc[3], t0 + 22);
    check("t3_overlap", overlap, 0);
    check("t3_n_done", n_done, 4);

    // Reset while waiting on the core
    do_reset();
    t0 = cyc;
    bus.req0_q = BASE_POINT; bus.req0_valid = 1'b1;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4_busy_rst", bus.busy, 0);
    repeat (12) tick();
    check("t4_n_done", n_done, 0);
    check("t4_n_ack", n_ack, 1);
    check("t4_out0", bus.req0_out, 0);
    clear_log();
    t0 = cyc;
    bus.req1_n = WIDTH'(1); bus.req1_q = BASE_POINT; bus.req1_valid = 1'b1;
    repeat (8) tick();
    check("t4_ack_cyc", ack_cyc[0], t0 + 1);
    check("t4_done_cyc", done_cyc[0], t0 + 6);
    check("t4_done_who", done_who[0], 1);
    check("t4_out1", bus.req1_out, p33);

    // Stray core_done in IDLE
    clear_log();
    stub_pulse = 1'b1;
    tick();
    stub_pulse = 1'b0;
    check("t5_busy", bus.busy, 0);
    repeat (3) tick();
    check("t5_n_ack", n_ack, 0);
    check("t5_n_done", n_done, 0);
    t0 = cyc;
    bus.req0_n = WIDTH'(2); bus.req0_q = WIDTH'(5); bus.req0_valid = 1'b1;
    repeat (8) tick();
    check("t5_ack_cyc", ack_cyc[0], t0 + 1);
    check("t5_done_cyc", done_cyc[0], t0 + 6);
    check("t5_out0", bus.req0_out, p22);
    check("t5_out1_hold", bus.req1_out, p33);

`ifdef CURVE25519_TIMEOUT_EN
    // Core never completes
    do_reset();
    stub_dead = 1'b1;
    t0 = cyc;
    bus.req1_q = BASE_POINT; bus.req1_valid = 1'b1;
    repeat (18) tick();
    check("t6_ack_cyc", ack_cyc[0], t0 + 1);
    check("t6_done_cyc", done_cyc[0], t0 + 18);
    check("t6_done_who", done_who[0], 1);
    check("t6_n_err", n_err, 1);
    check("t6_err_cyc", err_cyc[0], t0 + 18);
    check("t6_out1", bus.req1_out, 0);
    stub_dead = 1'b0;
    bus.req0_q = BASE_POINT; bus.req0_valid = 1'b1;
    repeat (12) tick();
    check("t6_requiet_ack", ack_cyc[1], t0 + 28);
`else
    check("err_count", n_err, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
